// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared constants and types for the EQ tap sequencer
//
// Purpose: coefficient geometry, tap index width and FSM state encoding
// shared by tap_sequencer and coef_bank_rf.
package eq_pkg;

  localparam int COEF_W      = 16;
  localparam int NTAPS       = 4;
  localparam int NBANKS      = 4;
  localparam int TAPNUM_W    = 8;
  localparam int TIMEOUT_DEF = 64;

  localparam int BANK_W = $clog2(NBANKS);
  localparam int IDX_W  = $clog2(NTAPS);

  typedef logic [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/coef_bank_rf.sv
// rtl/coef_bank_rf.sv - NBANKS x NTAPS coefficient register file
//
// Purpose: holds the EQ coefficient banks. One synchronous write port,
// one combinational read port, asynchronous clear.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low clear
//   we_i                 write strobe (already qualified by the caller)
//   wbank_i, widx_i      write bank / tap index
//   wdata_i              write data
//   rbank_i, ridx_i      read bank / tap index
//   rdata_o              read data, combinational
module coef_bank_rf
  import eq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [BANK_W-1:0] wbank_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  coef_t             wdata_i,
  input  logic [BANK_W-1:0] rbank_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output coef_t             rdata_o
);

  coef_t mem [NBANKS][NTAPS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NBANKS; b++) begin
        for (int t = 0; t < NTAPS; t++) begin
          mem[b][t] <= '0;
        end
      end
    end else if (we_i) begin
      mem[wbank_i][widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[rbank_i][ridx_i];

endmodule

// File: rtl/tap_sequencer.sv
// rtl/tap_sequencer.sv - streams EQ coefficients into the dsp FIR MAC per sample window
//
// Purpose: on each accepted sample, clears the dsp accumulator, issues the
// NTAPS coefficients of the latched bank one per cycle, then waits for the
// dsp done flag, reporting completion, overrun and timeout.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   sample_valid_i                new sample window pulse
//   eq_val_i                      bank select, latched on accept
//   coef_we_i/bank/idx/data       coefficient write port
//   clear_flags_i                 clears the sticky flags
//   dsp_done_i                    dsp result complete
//   tap_o, tapnum_o               coefficient and its index to the dsp
//   dsp_clk_en_o, dsp_clr_o       dsp clock enable / accumulator clear
//   busy_o, frame_done_o          status
//   overrun_o, timeout_o, coef_err_o  sticky error flags
module tap_sequencer
  import eq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sample_valid_i,
  input  logic [7:0]          eq_val_i,
  input  logic                coef_we_i,
  input  logic [BANK_W-1:0]   coef_bank_i,
  input  logic [7:0]          coef_idx_i,
  input  logic [COEF_W-1:0]   coef_data_i,
  input  logic                clear_flags_i,
  input  logic                dsp_done_i,
  output logic [COEF_W-1:0]   tap_o,
  output logic [TAPNUM_W-1:0] tapnum_o,
  output logic                dsp_clk_en_o,
  output logic                dsp_clr_o,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic                overrun_o,
  output logic                timeout_o,
  output logic                coef_err_o
);

  localparam int WCNT_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0]  LAST_K = IDX_W'(NTAPS - 1);
  localparam logic [WCNT_W-1:0] LAST_W = WCNT_W'(TIMEOUT - 1);

  seq_state_t        state;
  logic [BANK_W-1:0] bank_q;
  logic [IDX_W-1:0]  k_q;
  logic [WCNT_W-1:0] wcnt_q;

  logic [BANK_W-1:0] eq_bank;
  logic              unused_eq_bits;
  assign eq_bank        = eq_val_i[BANK_W-1:0];
  assign unused_eq_bits = ^eq_val_i[7:BANK_W];

  // Register file read address: the tap about to be driven on the next edge.
  logic [IDX_W-1:0] rd_idx;
  coef_t            rd_data;

  always_comb begin
    rd_idx = '0;
    if (state == ISSUE) begin
      rd_idx = k_q + IDX_W'(1);
    end
  end

  // Coefficient write qualification: out-of-range indices vanish silently,
  // writes into the bank currently being streamed are refused.
  logic wr_hit, wr_block, rf_we;
  assign wr_hit   = coef_we_i && (coef_idx_i < TAPNUM_W'(NTAPS));
  assign wr_block = wr_hit && (state != IDLE) && (coef_bank_i == bank_q);
  assign rf_we    = wr_hit && !wr_block;

  coef_bank_rf u_rf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (rf_we),
    .wbank_i (coef_bank_i),
    .widx_i  (coef_idx_i[IDX_W-1:0]),
    .wdata_i (coef_data_i),
    .rbank_i (bank_q),
    .ridx_i  (rd_idx),
    .rdata_o (rd_data)
  );

  // A sample landing in the same WAIT cycle as done starts the next frame
  // rather than counting as an overrun.
  logic done_in_wait, ovr_set, to_set;
  assign done_in_wait = (state == WAIT) && dsp_done_i;
  assign ovr_set      = sample_valid_i && (state != IDLE) && !done_in_wait;
  assign to_set       = (state == WAIT) && !dsp_done_i && (wcnt_q == LAST_W);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      bank_q       <= '0;
      k_q          <= '0;
      wcnt_q       <= '0;
      tap_o        <= '0;
      tapnum_o     <= '0;
      dsp_clk_en_o <= 1'b0;
      dsp_clr_o    <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      overrun_o    <= 1'b0;
      timeout_o    <= 1'b0;
      coef_err_o   <= 1'b0;
    end else begin
      dsp_clr_o    <= 1'b0;
      frame_done_o <= 1'b0;

      unique case (state)
        IDLE: begin
          if (sample_valid_i) begin
            bank_q    <= eq_bank;
            state     <= CLEAR;
            dsp_clr_o <= 1'b1;
            busy_o    <= 1'b1;
          end
        end

        CLEAR: begin
          state        <= ISSUE;
          k_q          <= rd_idx;
          tapnum_o     <= TAPNUM_W'(rd_idx);
          tap_o        <= rd_data;
          dsp_clk_en_o <= 1'b1;
        end

        ISSUE: begin
          if (k_q == LAST_K) begin
            state        <= WAIT;
            dsp_clk_en_o <= 1'b0;
            wcnt_q       <= '0;
          end else begin
            k_q      <= rd_idx;
            tapnum_o <= TAPNUM_W'(rd_idx);
            tap_o    <= rd_data;
          end
        end

        WAIT: begin
          if (dsp_done_i) begin
            frame_done_o <= 1'b1;
            if (sample_valid_i) begin
              bank_q    <= eq_bank;
              state     <= CLEAR;
              dsp_clr_o <= 1'b1;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else if (wcnt_q == LAST_W) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase

      // Sticky flags: a set event outranks a clear in the same cycle.
      overrun_o  <= ovr_set  | (overrun_o  & ~clear_flags_i);
      timeout_o  <= to_set   | (timeout_o  & ~clear_flags_i);
      coef_err_o <= wr_block | (coef_err_o & ~clear_flags_i);
    end
  end

endmodule

// File: doc/tap_sequencer.md
Name: tap_sequencer

Overview:
- Upstream control stage for the dsp FIR multiply-accumulate block.
- On each new sample window, it clears the dsp accumulator and streams the filter coefficients of the selected EQ bank to the dsp as tap/tapnum, one per cycle.
- It then waits for the dsp done flag and reports frame completion, overrun and timeout.
- It holds the coefficient banks in a small register file that software writes through a simple write port.

Parameters:
NTAPS, 4, taps per filter; tapnum runs 0..NTAPS-1
COEF_W, 16, coefficient width; matches the dsp tap input
NBANKS, 4, number of EQ coefficient banks; power of two
TIMEOUT, 64, maximum cycles spent in WAIT before abort

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
sample_valid_i  in  1  one-cycle pulse: new signal window is ready
eq_val_i  in  8  bank select; low $clog2(NBANKS) bits used; latched on sample accept
coef_we_i  in  1  coefficient write strobe
coef_bank_i  in  $clog2(NBANKS)  write bank
coef_idx_i  in  8  write tap index
coef_data_i  in  COEF_W  write data
clear_flags_i  in  1  clears sticky flags
dsp_done_i  in  1  dsp result complete
tap_o  out  COEF_W  coefficient to the dsp
tapnum_o  out  8  tap index to the dsp
dsp_clk_en_o  out  1  dsp clock enable; high during ISSUE only
dsp_clr_o  out  1  one-cycle accumulator clear to the dsp
busy_o  out  1  high whenever state != IDLE
frame_done_o  out  1  one-cycle pulse on normal frame completion
overrun_o  out  1  sticky: a sample arrived while busy
timeout_o  out  1  sticky: WAIT exceeded TIMEOUT
coef_err_o  out  1  sticky: write to the active bank while busy was dropped

Behaviour:
- All outputs are registered.
- Reset, asynchronous on rst_ni low:
  - state goes to IDLE.
  - The coefficient RAM and all outputs go to 0.
- FSM states: IDLE, CLEAR, ISSUE, WAIT.
- IDLE:
  - sample_valid_i=1 accepts the sample.
  - On accept, the bank is latched from eq_val_i and the FSM goes to CLEAR.
- CLEAR:
  - dsp_clr_o=1 for exactly one cycle; tap counter k=0.
  - Next state is ISSUE.
- ISSUE:
  - Each cycle drives tapnum_o=k, tap_o=coef[bank][k], dsp_clk_en_o=1.
  - k increments every cycle.
  - After k=NTAPS-1 is driven, the FSM goes to WAIT.
- WAIT:
  - dsp_clk_en_o=0, and tap_o/tapnum_o hold their last values.
  - A cycle counter starts at 0.
  - dsp_done_i=1 ends the frame: frame_done_o pulses and the FSM goes to IDLE.
  - If the counter reaches TIMEOUT-1 without done: timeout_o is set, the FSM goes to IDLE, and frame_done_o is not asserted.
- Latency, for accept at edge T:
  - dsp_clr_o is high in cycle T+1.
  - tapnum 0 is in cycle T+2.
  - tapnum NTAPS-1 is in cycle T+1+NTAPS.
  - WAIT starts at T+2+NTAPS.
- Overrun:
  - sample_valid_i while state is CLEAR, ISSUE or WAIT sets overrun_o, and the sample is dropped.
  - Exception: in the WAIT cycle where dsp_done_i=1, a simultaneous sample_valid_i is accepted. The FSM goes directly to CLEAR, frame_done_o still pulses, and no overrun is flagged.
- Coefficient writes:
  - A write occurs when coef_we_i=1 and coef_idx_i<NTAPS; writes with idx>=NTAPS are ignored silently.
  - When busy_o=1 and coef_bank_i equals the latched bank, the write is dropped and coef_err_o is set.
  - Otherwise the write lands at the clock edge and is readable from the next cycle.
- clear_flags_i clears overrun_o, timeout_o and coef_err_o. A set event in the same cycle as a clear wins.
- dsp_done_i outside WAIT is ignored.
- rst_ni asserted mid-frame returns the block to IDLE immediately, with dsp_clk_en_o=0 and the coefficients zeroed.

Decomposition:
- Package eq_pkg holds:
  - COEF_W, NTAPS, NBANKS, TAPNUM_W=8
  - typedef coef_t = logic [COEF_W-1:0]
  - enum seq_state_t {IDLE, CLEAR, ISSUE, WAIT}
- One sub-module, coef_bank_rf, holds the NBANKS×NTAPS register file:
  - one write port and one combinational read port.
  - asynchronous clear on rst_ni.
- The FSM, counters and flags live in tap_sequencer.

Test Plan:
- Load bank 0 with {4,1,2,1}, eq_val=0, pulse sample_valid, return done 3 cycles into WAIT -> dsp_clr_o high 1 cycle, then tap/tapnum (4,0),(1,1),(2,2),(1,3) on consecutive cycles, frame_done_o single pulse, busy_o low after.
- Load bank 2 with {7,7,7,7}, eq_val=8'h02 -> taps stream 7,7,7,7. Change eq_val to 0 mid-frame -> remaining taps still 7.
- Pulse sample_valid during ISSUE -> overrun_o=1 and the frame continues unchanged. clear_flags_i -> overrun_o=0.
- dsp_done_i and sample_valid_i in the same WAIT cycle -> frame_done_o pulses, dsp_clr_o high the next cycle, overrun_o stays 0.
- Never assert done -> timeout_o=1 after 64 WAIT cycles, no frame_done_o, busy_o=0.
- While busy on bank 0, write bank 0 idx 1 = 9 -> coef_err_o=1, next frame tap1 still 1. Write bank 1 -> accepted. Assert rst_ni=0 mid-ISSUE -> all outputs 0 asynchronously.
